// File: rtl/internal_framebuffer_pkg.sv
// Shared constants and types for the internal framebuffer stream reader.
package internal_framebuffer_pkg;

  localparam int FIFO_DEPTH      = 4;
  localparam int ISSUE_THRESHOLD = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } fb_state_e;

  function automatic int mask_width(input int data_width, input int strobe_width);
    return data_width / strobe_width;
  endfunction

endpackage

// File: rtl/fb_stream_skid_fifo.sv
// Four-entry first-word-fall-through FIFO that absorbs the RAM read latency
// ahead of the stream output. The entry count is exported so reads can be credited.
module fb_stream_skid_fifo
  import internal_framebuffer_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 push,
  input  logic [WIDTH-1:0]                     push_data,
  input  logic                                 pop,
  output logic                                 out_valid,
  output logic [WIDTH-1:0]                     out_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      count
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);

  logic [WIDTH-1:0]   mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [COUNT_W-1:0] count_r;
  logic               pop_s;

  assign pop_s     = pop && (count_r != '0);
  assign out_valid = (count_r != '0);
  assign out_data  = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage, pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push, pop_s})
        2'b10:   count_r <= count_r + COUNT_W'(1);
        2'b01:   count_r <= count_r - COUNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/internal_framebuffer_stream_reader.sv
// Streams a linear span of framebuffer RAM words onto an AXI-Stream master.
// Define RASTERIX_FB_STREAM_CLEAR_EN to add clear-on-read write-back ports.
module internal_framebuffer_stream_reader
  import internal_framebuffer_pkg::*;
#(
  parameter int ADDR_WIDTH         = 8,
  parameter int DATA_WIDTH         = 16,
  parameter int WRITE_STROBE_WIDTH = 8
) (
  input  logic                                       clk,
  input  logic                                       resetn,
  input  logic                                       start,
  input  logic [ADDR_WIDTH-1:0]                      startAddr,
  input  logic [ADDR_WIDTH:0]                        wordCount,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       ramEnable,
  output logic [ADDR_WIDTH-1:0]                      ramReadAddr,
  input  logic [DATA_WIDTH-1:0]                      ramReadData,
`ifdef RASTERIX_FB_STREAM_CLEAR_EN
  input  logic [DATA_WIDTH-1:0]                      clearValue,
  output logic                                       ramWriteEnable,
  output logic [ADDR_WIDTH-1:0]                      ramWriteAddr,
  output logic [DATA_WIDTH-1:0]                      ramWriteData,
  output logic [DATA_WIDTH/WRITE_STROBE_WIDTH-1:0]   ramWriteMask,
`endif
  output logic                                       m_axis_tvalid,
  input  logic                                       m_axis_tready,
  output logic [DATA_WIDTH-1:0]                      m_axis_tdata,
  output logic                                       m_axis_tlast
);

  localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] ONE_WORD = {{ADDR_WIDTH{1'b0}}, 1'b1};

  fb_state_e             state_r;
  fb_state_e             state_s;
  logic [ADDR_WIDTH:0]   remaining_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  in_flight_r;
  logic                  in_flight_last_r;
  logic                  done_r;
  logic                  accept_s;
  logic                  issue_s;
  logic                  credit_ok_s;
  logic                  last_beat_s;
  logic [COUNT_W-1:0]    fifo_count_s;
  logic                  fifo_valid_s;
  logic [DATA_WIDTH:0]   fifo_out_s;

  assign accept_s    = (state_r == IDLE) && start;
  // A read is only issued when the FIFO can still hold it plus the one already in flight.
  assign credit_ok_s = (4'(fifo_count_s) + 4'(in_flight_r)) <= 4'(ISSUE_THRESHOLD);
  assign last_beat_s = fifo_valid_s && m_axis_tready && fifo_out_s[DATA_WIDTH];

  // Next-state and read-issue decode.
  always_comb begin
    state_s = state_r;
    issue_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && (wordCount != '0)) begin
          state_s = STREAM;
        end else begin
          state_s = IDLE;
        end
      end
      STREAM: begin
        issue_s = (remaining_r != '0) && credit_ok_s;
        if (issue_s && (remaining_r == ONE_WORD)) begin
          state_s = DRAIN;
        end else begin
          state_s = STREAM;
        end
      end
      DRAIN: begin
        if (last_beat_s) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register, read address/count tracking and the done pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r          <= IDLE;
      remaining_r      <= '0;
      addr_r           <= '0;
      in_flight_r      <= 1'b0;
      in_flight_last_r <= 1'b0;
      done_r           <= 1'b0;
    end else begin
      state_r          <= state_s;
      done_r           <= last_beat_s || (accept_s && (wordCount == '0));
      in_flight_r      <= issue_s;
      in_flight_last_r <= issue_s && (remaining_r == ONE_WORD);
      if (accept_s) begin
        addr_r      <= startAddr;
        remaining_r <= wordCount;
      end else if (issue_s) begin
        addr_r      <= addr_r + ADDR_WIDTH'(1);
        remaining_r <= remaining_r - ONE_WORD;
      end
    end
  end

  fb_stream_skid_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (in_flight_r),
    .push_data ({in_flight_last_r, ramReadData}),
    .pop       (m_axis_tready),
    .out_valid (fifo_valid_s),
    .out_data  (fifo_out_s),
    .count     (fifo_count_s)
  );

  // Enable covers the final DRAIN cycle in which the last read's data returns.
  assign ramEnable     = (state_r == STREAM) || in_flight_r;
  assign ramReadAddr   = addr_r;
  assign busy          = (state_r != IDLE);
  assign done          = done_r;
  assign m_axis_tvalid = fifo_valid_s;
  assign m_axis_tdata  = fifo_out_s[DATA_WIDTH-1:0];
  assign m_axis_tlast  = fifo_out_s[DATA_WIDTH];

`ifdef RASTERIX_FB_STREAM_CLEAR_EN
  localparam int MASK_WIDTH = mask_width(DATA_WIDTH, WRITE_STROBE_WIDTH);

  logic [DATA_WIDTH-1:0] clear_value_r;
  logic [ADDR_WIDTH-1:0] in_flight_addr_r;

  // Clear value latched per transfer; the issued address follows its data for write-back.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clear_value_r    <= '0;
      in_flight_addr_r <= '0;
    end else begin
      if (accept_s) begin
        clear_value_r <= clearValue;
      end
      if (issue_s) begin
        in_flight_addr_r <= addr_r;
      end
    end
  end

  assign ramWriteEnable = in_flight_r;
  assign ramWriteAddr   = in_flight_addr_r;
  assign ramWriteData   = clear_value_r;
  assign ramWriteMask   = {MASK_WIDTH{1'b1}};
`endif

endmodule

// File: doc/internal_framebuffer_stream_reader.md
Name: internal_framebuffer_stream_reader

Overview:
Reader/streamer for one port of the multiplexed internal framebuffer RAM. On a start command it reads a linear span of framebuffer words and emits them on an AXI-Stream master with tlast on the final word. Typical use is tile write-back to external memory. It drives the port's enable, read address and (optionally) write signals, and absorbs the RAM's fixed 1-cycle read latency with a small skid FIFO, so stream backpressure never corrupts data.

Parameters:
ADDR_WIDTH, 8, RAM word address width.
DATA_WIDTH, 16, RAM word / stream data width.
WRITE_STROBE_WIDTH, 8, bits per write-mask lane; mask width = DATA_WIDTH / WRITE_STROBE_WIDTH.

Ports:
clk  in  1  clock.
resetn  in  1  reset, asynchronous, active-low.
start  in  1  command strobe; accepted only when busy=0.
startAddr  in  ADDR_WIDTH  first word address.
wordCount  in  ADDR_WIDTH+1  number of words (0..2^ADDR_WIDTH).
busy  out  1  high from the accepting edge until the final beat handshakes.
done  out  1  one-cycle pulse, cycle after the final beat or the zero-count start.
ramEnable  out  1  port-select request to the RAM mux.
ramReadAddr  out  ADDR_WIDTH  RAM read address.
ramReadData  in  DATA_WIDTH  RAM read data; valid 1 cycle after the address.
m_axis_tvalid  out  1  stream valid.
m_axis_tready  in  1  stream ready.
m_axis_tdata  out  DATA_WIDTH  stream data.
m_axis_tlast  out  1  high on the final word.

Behaviour:
- Reset (async assert, sync release): FSM in IDLE; busy, done, ramEnable, m_axis_tvalid and m_axis_tlast are 0; ramReadAddr and m_axis_tdata are 0; FIFO is empty; the in-flight flag is cleared.
- Reset mid-transfer: the transfer is aborted immediately and no done pulse is produced.
- FSM states:
  - IDLE -> STREAM when start=1 and wordCount!=0.
  - IDLE -> IDLE with done pulsed the next cycle when start=1 and wordCount=0; no RAM access occurs.
  - STREAM -> DRAIN when the last read is issued.
  - DRAIN -> IDLE when the last beat handshakes (tvalid & tready & tlast).
  - start is ignored while busy.
- Read issue: in STREAM, one read per cycle while remaining>0 and fifoCount + inFlight <= 2. inFlight means a read was issued in the previous cycle.
  - The address starts at startAddr and increments by 1, wrapping modulo 2^ADDR_WIDTH.
  - ramEnable is high from the cycle after acceptance through the cycle the last read data returns.
  - ramEnable stays high during credit stalls; ramReadAddr holds its value on stall cycles.
- Capture: the read issued in cycle k is pushed into the FIFO at the end of cycle k+1 (ramReadData valid in k+1).
- FIFO: depth 4, first-word-fall-through onto m_axis_*. Push and pop in the same cycle are allowed. The credit rule guarantees no overflow.
- Latency: start accepted at edge N; ramEnable high and ramReadAddr=startAddr in N+1; m_axis_tvalid high in N+3.
- Throughput: 1 word/cycle with tready held high.
- AXI-Stream rules: tdata and tlast are stable while tvalid & !tready; tvalid is never deasserted without a handshake.
- tlast is stored per FIFO entry and is set on the entry from read number wordCount.
- done pulses in the cycle after the tlast handshake; busy falls at the same edge.

Optional Feature:
RASTERIX_FB_STREAM_CLEAR_EN
- Defined: the block adds ports clearValue (in, DATA_WIDTH), ramWriteEnable (out, 1), ramWriteAddr (out, ADDR_WIDTH), ramWriteData (out, DATA_WIDTH) and ramWriteMask (out, mask width, all ones).
  - In the cycle a read's data returns (k+1), ramWriteEnable=1, ramWriteAddr = that read's address and ramWriteData = clearValue. This gives clear-on-read.
  - clearValue is sampled at start acceptance.
- Undefined: these ports are absent and the port is read-only.

Decomposition:
- Shared package internal_framebuffer_pkg: FIFO depth constant (4), the issue threshold (2), the FSM state enum (IDLE/STREAM/DRAIN), and a function for mask width.
- One sub-module: fb_stream_skid_fifo, a 4-entry FWFT FIFO of {tlast, data} exposing its count.

Test Plan:
- startAddr=0x10, wordCount=4, tready=1, RAM word = address -> tdata 0x10,0x11,0x12,0x13; tlast on 0x13; first tvalid at N+3; done one pulse.
- startAddr=0xFE, wordCount=4 -> addresses 0xFE,0xFF,0x00,0x01 in order.
- wordCount=8, tready toggling 1,0,0,1 repeatedly -> all 8 words in order, none lost or duplicated, tdata stable during stalls, FIFO count never exceeds 4.
- wordCount=0 -> ramEnable stays 0, no tvalid, done pulses the cycle after start.
- resetn low for 1 cycle mid-transfer (word 3 of 8) -> tvalid, ramEnable and busy go 0 immediately, no done; a new start afterwards streams correctly.
- RASTERIX_FB_STREAM_CLEAR_EN defined, clearValue=0xABCD, span 0x20..0x23 -> stream carries the old data; the RAM afterwards holds 0xABCD at 0x20..0x23.
